// File: rtl/color_cmd_sequencer_if.sv
// Command stream interface for color_cmd_sequencer: valid/ready handshake carrying
// a 2-bit colour code and the idle-gap length that follows it.
interface color_cmd_sequencer_if #(
    parameter int unsigned HOLD_WIDTH = 4
);
    logic                  cmd_valid;
    logic [1:0]            cmd_code;
    logic [HOLD_WIDTH-1:0] cmd_hold;
    logic                  cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/color_cmd_sequencer.sv
// FIFO-buffered feeder for the colour FSM: issues each command for one cycle, then idle code for cmd_hold cycles.
// Defining COLOR_CMD_SEQ_FLUSH_EN adds a synchronous active-high flush input.
module color_cmd_sequencer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef COLOR_CMD_SEQ_FLUSH_EN
    input  logic                    flush,
`endif
    color_cmd_sequencer_if.slave    cmd,
    output logic [1:0]              out,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 2 + HOLD_WIDTH;
    localparam logic [1:0]  IDLE_CODE = 2'h3;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [LW-1:0]         r_level;
    logic [HOLD_WIDTH-1:0] r_cnt;
    logic [1:0]            r_out;
    state_t                r_state;

    logic                  w_flush;
    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [EW-1:0]         w_head;
    logic [1:0]            w_head_code;
    logic [HOLD_WIDTH-1:0] w_head_hold;

`ifdef COLOR_CMD_SEQ_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_ready     = (r_level != LW'(DEPTH)) && !w_flush;
    assign w_push      = cmd.cmd_valid && w_ready;
    assign w_pop       = (r_state == ST_IDLE) && (r_level != '0);
    assign w_head      = r_mem[r_rptr];
    assign w_head_code = w_head[EW-1 -: 2];
    assign w_head_hold = w_head[HOLD_WIDTH-1:0];

    assign cmd.cmd_ready = w_ready;
    assign out           = r_out;
    assign level         = r_level;
    assign busy          = (r_state == ST_GAP) || (r_level != '0);

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd.cmd_code, cmd.cmd_hold};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
            r_out   <= IDLE_CODE;
            r_state <= ST_IDLE;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
            r_out   <= IDLE_CODE;
            r_state <= ST_IDLE;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (r_level == '0) begin
                        r_out <= IDLE_CODE;
                    end else begin
                        r_out <= w_head_code;
                        if (w_head_hold != '0) begin
                            r_cnt   <= w_head_hold;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_out <= IDLE_CODE;
                    r_cnt <= r_cnt - 1'b1;
                    // Leaving on cnt==1 lets the next pop land on the following edge.
                    if (r_cnt == HOLD_WIDTH'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_out   <= IDLE_CODE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_color_cmd_sequencer.sv
// Directed self-checking bench for color_cmd_sequencer (DEPTH=4, HOLD_WIDTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_color_cmd_sequencer;
    logic       clk;
    logic       rst;
    logic [1:0] out;
    logic       busy;
    logic [2:0] level;
`ifdef COLOR_CMD_SEQ_FLUSH_EN
    logic       flush;
`endif

    int errors;
    int checks;

    color_cmd_sequencer_if #(.HOLD_WIDTH(4)) cmd_if ();

    color_cmd_sequencer #(
        .DEPTH      (4),
        .HOLD_WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef COLOR_CMD_SEQ_FLUSH_EN
        .flush (flush),
`endif
        .cmd   (cmd_if),
        .out   (out),
        .busy  (busy),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++; if (out !== 2'h3) begin errors++; $display("FAIL reset_out got=%0h exp=3", out); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", cmd_if.cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out !== 2'h3) begin errors++; $display("FAIL reset_idle[%0d] got=%0h exp=3", i, out); end
        end
    endtask

    task automatic test_single;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_code = 2'h1; cmd_if.cmd_hold = 4'd3;
        tick();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        tick();
        checks++; if (out !== 2'h1) begin errors++; $display("FAIL single_issue got=%0h exp=1", out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_issue got=%0b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out !== 2'h3) begin errors++; $display("FAIL single_gap_out[%0d] got=%0h exp=3", i, out); end
            if (i < 2) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy[%0d] got=%0b exp=1", i, busy); end
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy got=%0b exp=0", busy); end
        checks++; if (out !== 2'h3) begin errors++; $display("FAIL single_done_out got=%0h exp=3", out); end
    endtask

    task automatic test_back_to_back;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_hold = 4'd0;
        cmd_if.cmd_code = 2'h1;
        tick();
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level0 got=%0d exp=1", level); end
        cmd_if.cmd_code = 2'h1;
        tick();
        checks++; if (out !== 2'h1) begin errors++; $display("FAIL b2b_out0 got=%0h exp=1", out); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level1 got=%0d exp=1", level); end
        cmd_if.cmd_code = 2'h0;
        tick();
        checks++; if (out !== 2'h1) begin errors++; $display("FAIL b2b_out1 got=%0h exp=1", out); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level2 got=%0d exp=1", level); end
        cmd_if.cmd_valid = 1'b0;
        tick();
        checks++; if (out !== 2'h0) begin errors++; $display("FAIL b2b_out2 got=%0h exp=0", out); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level3 got=%0d exp=0", level); end
        tick();
        checks++; if (out !== 2'h3) begin errors++; $display("FAIL b2b_idle got=%0h exp=3", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_full;
        logic [1:0] fill [4];
        logic [1:0] drain [4];
        int         got;
        int         bad;
        fill[0] = 2'h1; fill[1] = 2'h2; fill[2] = 2'h0; fill[3] = 2'h1;
        drain[0] = 2'h2; drain[1] = 2'h0; drain[2] = 2'h1; drain[3] = 2'h2;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_code = 2'h0; cmd_if.cmd_hold = 4'd15;
        tick();
        for (int i = 0; i < 4; i++) begin
            cmd_if.cmd_code = fill[i];
            tick();
            if (i == 0) begin
                checks++; if (out !== 2'h0) begin errors++; $display("FAIL full_first_issue got=%0h exp=0", out); end
            end
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", level); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", cmd_if.cmd_ready); end
        // Offered data wiggles while full and must never be captured.
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            cmd_if.cmd_code = 2'(k % 3);
            cmd_if.cmd_hold = 4'(k);
            tick();
            if (level !== 3'd4 || cmd_if.cmd_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_hold_off bad_cycles=%0d exp=0", bad); end
        cmd_if.cmd_code = 2'h2; cmd_if.cmd_hold = 4'd0;
        tick();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_after_pop_level got=%0d exp=3", level); end
        checks++; if (out !== 2'h1) begin errors++; $display("FAIL full_second_issue got=%0h exp=1", out); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready got=%0b exp=1", cmd_if.cmd_ready); end
        tick();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_refill_level got=%0d exp=4", level); end
        got = 0;
        for (int c = 0; c < 200 && got < 4; c++) begin
            tick();
            if (out !== 2'h3) begin
                checks++; if (out !== drain[got]) begin errors++; $display("FAIL full_drain[%0d] got=%0h exp=%0h", got, out, drain[got]); end
                got++;
            end
        end
        checks++; if (got != 4) begin errors++; $display("FAIL full_drain_count got=%0d exp=4", got); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_wrap;
        logic [1:0] exp;
        cmd_if.cmd_hold = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_code  = 2'(i % 3);
            tick();
            if (i > 0) begin
                exp = 2'((i - 1) % 3);
                checks++; if (out !== exp) begin errors++; $display("FAIL wrap_out[%0d] got=%0h exp=%0h", i - 1, out, exp); end
            end
        end
        cmd_if.cmd_valid = 1'b0;
        tick();
        checks++; if (out !== 2'h0) begin errors++; $display("FAIL wrap_out[9] got=%0h exp=0", out); end
        tick();
        checks++; if (out !== 2'h3) begin errors++; $display("FAIL wrap_idle got=%0h exp=3", out); end
    endtask

    task automatic test_reset_mid_op;
        int bad;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_code = 2'h1; cmd_if.cmd_hold = 4'd5;
        tick();
        cmd_if.cmd_code = 2'h2; cmd_if.cmd_hold = 4'd0;
        tick();
        checks++; if (out !== 2'h1) begin errors++; $display("FAIL mid_issue got=%0h exp=1", out); end
        cmd_if.cmd_code = 2'h0;
        tick();
        cmd_if.cmd_code = 2'h1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level got=%0d exp=3", level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%0b exp=1", busy); end
`ifdef COLOR_CMD_SEQ_FLUSH_EN
        flush = 1'b1;
        #1;
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", cmd_if.cmd_ready); end
        tick();
        flush = 1'b0;
`else
        #2;
        rst = 1'b0;
        #1;
`endif
        checks++; if (out !== 2'h3) begin errors++; $display("FAIL mid_clear_out got=%0h exp=3", out); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_clear_level got=%0d exp=0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_clear_busy got=%0b exp=0", busy); end
`ifndef COLOR_CMD_SEQ_FLUSH_EN
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_clear_ready got=%0b exp=1", cmd_if.cmd_ready); end
        #2;
        rst = 1'b1;
`endif
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out !== 2'h3 || level !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_stale bad_cycles=%0d exp=0", bad); end

        // Asynchronous reset while a real code is on out.
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_code = 2'h2; cmd_if.cmd_hold = 4'd4;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        checks++; if (out !== 2'h2) begin errors++; $display("FAIL async_pre_out got=%0h exp=2", out); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out !== 2'h3) begin errors++; $display("FAIL async_out got=%0h exp=3", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%0b exp=0", busy); end
        #2;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out !== 2'h3) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL async_no_stale bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_code  = 2'h3;
        cmd_if.cmd_hold  = 4'd0;
`ifdef COLOR_CMD_SEQ_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_wrap();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
